// File: rtl/ps2_calc_pkg.sv
// Shared definitions for the PS/2 calculator: scan codes, state/op encodings
// and the 7-segment glyph table.
package ps2_calc_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ADD   = 8'h79;
    localparam logic [7:0] SC_SUB   = 8'h7B;
    localparam logic [7:0] SC_MUL   = 8'h7C;
    localparam logic [7:0] SC_EQ    = 8'h55;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ESC   = 8'h76;

    localparam logic [7:0] SC_D0 = 8'h45;
    localparam logic [7:0] SC_D1 = 8'h16;
    localparam logic [7:0] SC_D2 = 8'h1E;
    localparam logic [7:0] SC_D3 = 8'h26;
    localparam logic [7:0] SC_D4 = 8'h25;
    localparam logic [7:0] SC_D5 = 8'h2E;
    localparam logic [7:0] SC_D6 = 8'h36;
    localparam logic [7:0] SC_D7 = 8'h3D;
    localparam logic [7:0] SC_D8 = 8'h3E;
    localparam logic [7:0] SC_D9 = 8'h46;

    // One-hot so the state drives Led[2:0] directly.
    typedef enum logic [2:0] {
        ST_ENTER_A = 3'b001,
        ST_ENTER_B = 3'b010,
        ST_RESULT  = 3'b100
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } op_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Returns {is_digit, value}.
    function automatic logic [4:0] scan_to_digit(input logic [7:0] c);
        logic [4:0] r;
        case (c)
            SC_D0: r = 5'h10;  SC_D1: r = 5'h11;  SC_D2: r = 5'h12;  SC_D3: r = 5'h13;
            SC_D4: r = 5'h14;  SC_D5: r = 5'h15;  SC_D6: r = 5'h16;  SC_D7: r = 5'h17;
            SC_D8: r = 5'h18;  SC_D9: r = 5'h19;  default: r = 5'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_calc_top_ps2_rx.sv
// PS/2 device-to-host receiver: synchronizers, falling-edge detect, 11-bit
// frame shifter and a mid-frame stall timeout. Parity is sampled but not checked.
module ps2_rx #(
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ps_clk,
    input  logic       i_ps_data,
    output logic [7:0] o_byte,
    output logic       o_byte_valid
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic          r_clk_s1, r_clk_s2, r_clk_prev;
    logic          r_dat_s1, r_dat_s2;
    logic [3:0]    r_cnt;
    logic [7:0]    r_shift;
    logic [7:0]    r_byte;
    logic          r_valid;
    logic [TW-1:0] r_tmo;
    logic          w_fall;

    assign w_fall       = r_clk_prev & ~r_clk_s2;
    assign o_byte       = r_byte;
    assign o_byte_valid = r_valid;

    // r_cnt: 0 idle, 1..8 data bits, 9 parity, 10 stop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_cnt      <= 4'd0;
            r_shift    <= 8'h00;
            r_byte     <= 8'h00;
            r_valid    <= 1'b0;
            r_tmo      <= '0;
        end else begin
            r_clk_s1   <= i_ps_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= i_ps_data;
            r_dat_s2   <= r_dat_s1;
            r_valid    <= 1'b0;
            if (w_fall) begin
                r_tmo <= '0;
                if (r_cnt == 4'd0) begin
                    if (!r_dat_s2) r_cnt <= 4'd1;
                end else if (r_cnt <= 4'd8) begin
                    r_shift <= {r_dat_s2, r_shift[7:1]};
                    r_cnt   <= r_cnt + 4'd1;
                end else if (r_cnt == 4'd9) begin
                    r_cnt <= 4'd10;
                end else begin
                    r_cnt <= 4'd0;
                    if (r_dat_s2) begin
                        r_byte  <= r_shift;
                        r_valid <= 1'b1;
                    end
                end
            end else if (r_cnt != 4'd0) begin
                if (r_tmo == TW'(TIMEOUT_CYC - 1)) begin
                    r_cnt <= 4'd0;
                    r_tmo <= '0;
                end else begin
                    r_tmo <= r_tmo + 1'b1;
                end
            end else begin
                r_tmo <= '0;
            end
        end
    end
endmodule

// File: rtl/ps2_calc_top.sv
// PS/2 keyboard single-digit calculator: scan-code decoder, calculator FSM,
// ALU and 7-segment/LED display.
module ps2_calc_top
    import ps2_calc_pkg::*;
#(
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       PS_clk,
    input  logic       PS_data,
    output logic [3:0] Led,
    output logic [7:0] Seg
);
    logic [7:0]  w_byte;
    logic        w_byte_valid;
    logic        r_break;
    logic        w_evt;
    logic [4:0]  w_dig;
    logic        w_is_digit, w_is_op, w_is_eq, w_is_esc;
    op_t         w_op_code;

    state_t      r_state, w_state_n;
    logic [3:0]  r_a, w_a_n, r_b, w_b_n;
    op_t         r_op, w_op_n;
    logic        r_a_valid, w_a_valid_n, r_b_valid, w_b_valid_n;
    logic        r_range, w_range_n;
    logic [7:0]  r_seg, w_seg_n;
    logic [7:0]  w_r;
    logic [3:0]  w_abs_lo;

    ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
        .clk          (clk),
        .rst          (rst),
        .i_ps_clk     (PS_clk),
        .i_ps_data    (PS_data),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid)
    );

    // A byte following F0 is the release of a key and is swallowed here.
    always_ff @(posedge clk) begin
        if (!rst)                             r_break <= 1'b0;
        else if (w_byte_valid && r_break)     r_break <= 1'b0;
        else if (w_byte_valid && w_byte == SC_BREAK) r_break <= 1'b1;
    end

    assign w_evt      = w_byte_valid && !r_break && w_byte != SC_BREAK && w_byte != SC_EXT;
    assign w_dig      = scan_to_digit(w_byte);
    assign w_is_digit = w_evt && w_dig[4];
    assign w_is_op    = w_evt && (w_byte == SC_ADD || w_byte == SC_SUB || w_byte == SC_MUL);
    assign w_is_eq    = w_evt && (w_byte == SC_EQ || w_byte == SC_ENTER);
    assign w_is_esc   = w_evt && w_byte == SC_ESC;
    assign w_op_code  = (w_byte == SC_SUB) ? OP_SUB : (w_byte == SC_MUL) ? OP_MUL : OP_ADD;

    always_comb begin
        w_r = {4'b0, r_a} + {4'b0, r_b};
        case (r_op)
            OP_SUB:  w_r = {4'b0, r_a} - {4'b0, r_b};
            OP_MUL:  w_r = {4'b0, r_a} * {4'b0, r_b};
            default: w_r = {4'b0, r_a} + {4'b0, r_b};
        endcase
    end
    // Low nibble of -R equals the two's complement of R's low nibble.
    assign w_abs_lo = w_r[7] ? (~w_r[3:0] + 4'd1) : w_r[3:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_ENTER_A;
            r_a       <= 4'd0;
            r_b       <= 4'd0;
            r_op      <= OP_ADD;
            r_a_valid <= 1'b0;
            r_b_valid <= 1'b0;
            r_range   <= 1'b0;
            r_seg     <= 8'hFF;
        end else begin
            r_state   <= w_state_n;
            r_a       <= w_a_n;
            r_b       <= w_b_n;
            r_op      <= w_op_n;
            r_a_valid <= w_a_valid_n;
            r_b_valid <= w_b_valid_n;
            r_range   <= w_range_n;
            r_seg     <= w_seg_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_a_n       = r_a;
        w_b_n       = r_b;
        w_op_n      = r_op;
        w_a_valid_n = r_a_valid;
        w_b_valid_n = r_b_valid;
        w_range_n   = r_range;
        w_seg_n     = r_seg;
        if (w_is_esc) begin
            w_state_n   = ST_ENTER_A;
            w_a_n       = 4'd0;
            w_b_n       = 4'd0;
            w_op_n      = OP_ADD;
            w_a_valid_n = 1'b0;
            w_b_valid_n = 1'b0;
            w_range_n   = 1'b0;
            w_seg_n     = 8'hFF;
        end else begin
            case (r_state)
                ST_ENTER_A: begin
                    if (w_is_digit) begin
                        w_a_n       = w_dig[3:0];
                        w_a_valid_n = 1'b1;
                        w_seg_n     = {1'b1, hex_to_seg(w_dig[3:0])};
                    end else if (w_is_op && r_a_valid) begin
                        w_op_n    = w_op_code;
                        w_state_n = ST_ENTER_B;
                        w_seg_n   = 8'hFF;
                    end
                end
                ST_ENTER_B: begin
                    if (w_is_digit) begin
                        w_b_n       = w_dig[3:0];
                        w_b_valid_n = 1'b1;
                        w_seg_n     = {1'b1, hex_to_seg(w_dig[3:0])};
                    end else if (w_is_eq && r_b_valid) begin
                        w_range_n = w_r[7] | (|w_r[6:4]);
                        w_seg_n   = {1'b1, hex_to_seg(w_abs_lo)};
                        w_state_n = ST_RESULT;
                    end
                end
                default: begin
                    if (w_is_digit) begin
                        w_a_n       = w_dig[3:0];
                        w_b_valid_n = 1'b0;
                        w_range_n   = 1'b0;
                        w_seg_n     = {1'b1, hex_to_seg(w_dig[3:0])};
                        w_state_n   = ST_ENTER_A;
                    end
                end
            endcase
        end
    end

    assign Led = {r_range, r_state};
    assign Seg = r_seg;
endmodule

// File: tb/tb_ps2_calc_top.sv
// Directed bench for ps2_calc_top: bit-banged PS/2 frames, Led/Seg checked after each step.
module tb_ps2_calc_top;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       PS_clk = 1'b1;
    logic       PS_data = 1'b1;
    logic [3:0] Led;
    logic [7:0] Seg;
    int         n_assert = 0;
    int         n_fail = 0;

    ps2_calc_top dut (
        .clk     (clk),
        .rst     (rst),
        .PS_clk  (PS_clk),
        .PS_data (PS_data),
        .Led     (Led),
        .Seg     (Seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] exp_led, input logic [7:0] exp_seg);
        n_assert++;
        assert (Led === exp_led) else begin
            n_fail++;
            $error("FAIL %s Led observed=%b expected=%b", tag, Led, exp_led);
        end
        n_assert++;
        assert (Seg === exp_seg) else begin
            n_fail++;
            $error("FAIL %s Seg observed=%h expected=%h", tag, Seg, exp_seg);
        end
    endtask

    // Sends the first nbits of a frame; PS_clk phases are 10 ns (one clk cycle).
    task automatic ps2_bits(input logic [7:0] b, input logic stop_bit, input logic bad_par,
                            input int nbits);
        logic [10:0] f;
        f = {stop_bit, (~^b) ^ bad_par, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            PS_data = f[i];
            #10 PS_clk = 1'b0;
            #10 PS_clk = 1'b1;
        end
        PS_data = 1'b1;
        #40;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        ps2_bits(b, 1'b1, 1'b0, 11);
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 4'b0001, 8'hFF);
        rst = 1'b1;

        send(8'h3E); send(8'hF0); send(8'h3E);
        check("digit8", 4'b0001, 8'h80);
        send(8'h79); send(8'hF0); send(8'h79);
        check("op_add", 4'b0010, 8'hFF);
        send(8'h3D); send(8'hF0); send(8'h3D);
        check("digit7", 4'b0010, 8'hF8);
        send(8'h55); send(8'hF0); send(8'h55);
        check("8plus7", 4'b0100, 8'h8E);

        send(8'h26);
        check("result_digit3", 4'b0001, 8'hB0);
        send(8'h7B); send(8'h3D); send(8'h55);
        check("3minus7", 4'b1100, 8'h99);

        ps2_bits(8'h3E, 1'b0, 1'b0, 11);
        check("bad_stop", 4'b1100, 8'h99);

        ps2_bits(8'h16, 1'b1, 1'b1, 11);
        check("bad_parity", 4'b0001, 8'hF9);

        send(8'h1C);
        check("unknown_code", 4'b0001, 8'hF9);

        send(8'h46); send(8'h7C);
        check("op_mul", 4'b0010, 8'hFF);
        send(8'h46); send(8'h5A);
        check("9times9", 4'b1100, 8'hF9);

        send(8'h76);
        check("esc", 4'b0001, 8'hFF);

        send(8'h55);
        check("eq_ignored", 4'b0001, 8'hFF);

        ps2_bits(8'h26, 1'b1, 1'b0, 4);
        repeat (5100) @(posedge clk);
        #1;
        send(8'h26);
        check("after_timeout", 4'b0001, 8'hB0);

        send(8'hE0); send(8'h79);
        check("ext_op", 4'b0010, 8'hFF);

        ps2_bits(8'h3E, 1'b1, 1'b0, 5);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_midframe", 4'b0001, 8'hFF);
        rst = 1'b1;
        send(8'h16);
        check("after_reset_frame", 4'b0001, 8'hF9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
